mic_pair_emulator: RTL and testbench
====================================

# mic_pair_emulator

Synthesizable stimulus source for the two-channel microphone time-difference path. It drives the active-low `microphone_left` / `microphone_right` lines with a programmable burst of low pulses on each channel, with the lagging channel offset by an exact cycle count. It sits in front of `microphone_interface`, both on the FPGA for self-test and in benches as a cycle-exact stimulus. Its output delay must reappear as that block's `leftfirst_state_cnt` / `rightfirst_state_cnt`.

## Interface
- `DLY_W`, 17: width of `delay`; matches the interface's state counters.
- `LEN_W`, 8: width of `pulse_len` and `gap_len`.
- `NUM_W`, 3: width of `pulse_num`.
- Clocking: one clock `HCLK`; reset `HRESET` is synchronous and active-high.
- `HCLK`  in  1  system clock (50 MHz).
- `HRESET`  in  1  synchronous, active-high reset.
- `start`  in  1  launch request, one cycle; sampled only in IDLE.
- `lead_right`  in  1  0: left leads; 1: right leads.
- `delay`  in  DLY_W  lag-channel offset in cycles; 0 means simultaneous.
- `pulse_len`  in  LEN_W  low time per pulse in cycles; 0 is treated as 1.
- `gap_len`  in  LEN_W  high time between pulses in cycles; 0 is treated as 1.
- `pulse_num`  in  NUM_W  pulses per burst; 0 is treated as 1.
- `microphone_left`  out  1  active-low left line; idle high.
- `microphone_right`  out  1  active-low right line; idle high.
- `busy`  out  1  high while state ≠ IDLE.
- `done`  out  1  one-cycle pulse at burst completion.

## Operation
- Config inputs are latched on the cycle `start` is accepted. Later changes to them have no effect until the next launch.
- Top FSM states and transitions:
  - IDLE: on `start`, lead generator go is asserted combinationally.
    - If `delay == 0`, lag go is asserted in the same cycle and the FSM moves to RUN.
    - Otherwise the delay counter `dcnt` is loaded with `delay` and the FSM moves to WAIT.
  - WAIT: `dcnt` decrements each cycle. When `dcnt == 1`, lag go is asserted and the FSM moves to RUN.
  - RUN: when both generators report inactive, move to DONE.
  - DONE: `done = 1` for one cycle, then move to IDLE.
- `start` outside IDLE is ignored: no queueing, no restart.
- Lead/lag mapping: `lead_right = 0` means lead = left, lag = right. `lead_right = 1` swaps them.
- Each channel has its own burst generator with states IDLE, LOW and HIGH, a LEN_W down-counter and a NUM_W pulse counter.
  - On go, the generator enters LOW with its output 0. LOW lasts `pulse_len` cycles.
  - After LOW, it enters HIGH for `gap_len` cycles if pulses remain; otherwise it goes to IDLE with output 1.
  - `active` is high whenever the generator is not in IDLE.
- The lead burst may finish during WAIT; this is legal, and the lag channel still fires on time.
- Burst length in cycles is N·`pulse_len` + (N−1)·`gap_len`.

## Timing
- Cycle 0 is the cycle in which `start` is sampled high in IDLE.
- Lead output falls at cycle 1. Lag output falls at cycle 1 + `delay`. Both fall at cycle 1 when `delay == 0`.
- `busy` rises at cycle 1.
- `done` is high in the cycle after the later output returns high. `busy` falls the cycle after `done`.
- Reset values: both microphone lines 1, `busy` 0, `done` 0, all FSMs in IDLE, all counters 0.
- Reset asserted mid-burst: at the next edge both lines return high and `done` is not pulsed.
- Maximum `delay` is 2^17−1 cycles; there is no wrap, and `dcnt` never underflows.
- All outputs are registered, with no combinational path from inputs to the microphone lines.

## Structure
- Package `mic_emu_pkg` holds:
  - width constants `DLY_W`, `LEN_W`, `NUM_W`;
  - the top state enum (IDLE, WAIT, RUN, DONE);
  - the generator state enum (IDLE, LOW, HIGH).
- Sub-module `mic_burst_gen` (ports: go, `pulse_len`, `gap_len`, `pulse_num`, out, active) is instantiated twice.
- The top holds the FSM, the config latch, `dcnt` and the lead/lag swap mux.

## Test plan
- Left lead, `pulse_len` = 10, `gap_len` = 5, `pulse_num` = 3, `delay` = 7000:
  - left is low in cycles 1–10, 16–25 and 31–40;
  - right is low in cycles 7001–7010, 7016–7025 and 7031–7040;
  - `done` is high at cycle 7042.
- Same configuration with `lead_right` = 1: the left and right waveforms are exactly swapped.
- `delay` = 0, `pulse_num` = 1, `pulse_len` = 10: both lines are low in cycles 1–10, and `done` is high at cycle 12.
- `start` pulsed again at cycle 50 of an active burst: the waveform is unchanged and exactly one `done` pulse occurs.
- `HRESET` asserted at cycle 5 of a burst: both lines are high at cycle 6, `busy` = 0, and no `done` pulse occurs.
- Loopback into `microphone_interface` with `delay` = 7500, left lead: the captured `leftfirst_state_cnt` equals 7500 (within the interface's stated offset). With `pulse_len`, `gap_len` and `pulse_num` all 0, a single 1-cycle pulse is produced.

Source files
------------

// File: rtl/mic_emu_pkg.sv
// Shared widths, state encodings and helpers for the two-channel microphone stimulus source.
package mic_emu_pkg;

  localparam int DLY_W = 17;
  localparam int LEN_W = 8;
  localparam int NUM_W = 3;

  typedef enum logic [1:0] {
    T_IDLE,
    T_WAIT,
    T_RUN,
    T_DONE
  } top_state_e;

  typedef enum logic [1:0] {
    G_IDLE,
    G_LOW,
    G_HIGH
  } gen_state_e;

  // A programmed length of zero would give a zero-cycle phase; clamp it to one.
  function automatic logic [LEN_W-1:0] len_min1(input logic [LEN_W-1:0] v);
    return (v == '0) ? LEN_W'(1) : v;
  endfunction

  function automatic logic [NUM_W-1:0] num_min1(input logic [NUM_W-1:0] v);
    return (v == '0) ? NUM_W'(1) : v;
  endfunction

endpackage

// File: rtl/mic_burst_gen.sv
// One channel: on go, emits pulse_num active-low pulses of pulse_len cycles separated by gap_len high cycles.
module mic_burst_gen
  import mic_emu_pkg::*;
(
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             go,
  input  logic [LEN_W-1:0] pulse_len,
  input  logic [LEN_W-1:0] gap_len,
  input  logic [NUM_W-1:0] pulse_num,
  output logic             out,
  output logic             active,
  output logic [1:0]       state_dbg
);

  gen_state_e       state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [NUM_W-1:0] pcnt_q, pcnt_d;
  logic [LEN_W-1:0] plen_q, plen_d;
  logic [LEN_W-1:0] glen_q, glen_d;
  logic             out_q, out_d;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= G_IDLE;
      cnt_q   <= '0;
      pcnt_q  <= '0;
      plen_q  <= '0;
      glen_q  <= '0;
      out_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      plen_q  <= plen_d;
      glen_q  <= glen_d;
      out_q   <= out_d;
    end
  end

  // cnt holds the cycles left in the current phase minus one; pcnt the pulses left after this one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pcnt_d  = pcnt_q;
    plen_d  = plen_q;
    glen_d  = glen_q;
    out_d   = out_q;
    if (go) begin
      state_d = G_LOW;
      out_d   = 1'b0;
      plen_d  = len_min1(pulse_len);
      glen_d  = len_min1(gap_len);
      cnt_d   = len_min1(pulse_len) - LEN_W'(1);
      pcnt_d  = num_min1(pulse_num) - NUM_W'(1);
    end else begin
      case (state_q)
        G_LOW: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - LEN_W'(1);
          end else if (pcnt_q == '0) begin
            state_d = G_IDLE;
            out_d   = 1'b1;
          end else begin
            state_d = G_HIGH;
            out_d   = 1'b1;
            cnt_d   = glen_q - LEN_W'(1);
            pcnt_d  = pcnt_q - NUM_W'(1);
          end
        end
        G_HIGH: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - LEN_W'(1);
          end else begin
            state_d = G_LOW;
            out_d   = 1'b0;
            cnt_d   = plen_q - LEN_W'(1);
          end
        end
        default: begin
          state_d = G_IDLE;
          out_d   = 1'b1;
        end
      endcase
    end
  end

  assign out       = out_q;
  assign active    = (state_q != G_IDLE);
  assign state_dbg = state_q;

endmodule

// File: rtl/mic_pair_emulator.sv
// Drives left/right active-low microphone lines with matched bursts, the lagging channel offset by delay cycles.
module mic_pair_emulator
  import mic_emu_pkg::*;
(
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             start,
  input  logic             lead_right,
  input  logic [DLY_W-1:0] delay,
  input  logic [LEN_W-1:0] pulse_len,
  input  logic [LEN_W-1:0] gap_len,
  input  logic [NUM_W-1:0] pulse_num,
  output logic             microphone_left,
  output logic             microphone_right,
  output logic             busy,
  output logic             done,
  output logic [5:0]       state_dbg
);

  // Handshake: start is a one-cycle request taken only in IDLE; there is no ready,
  // the caller watches busy, and requests while busy are dropped.
  top_state_e       state_q, state_d;
  logic [DLY_W-1:0] dcnt_q, dcnt_d;
  logic             lead_right_q, lead_right_d;
  logic [LEN_W-1:0] plen_q, plen_d, glen_q, glen_d;
  logic [NUM_W-1:0] pnum_q, pnum_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             lead_go, lag_go, left_go, right_go;
  logic             left_active, right_active;
  logic             idle, lr_sel;
  logic [LEN_W-1:0] plen_sel, glen_sel;
  logic [NUM_W-1:0] pnum_sel;
  logic [1:0]       left_dbg, right_dbg;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q      <= T_IDLE;
      dcnt_q       <= '0;
      lead_right_q <= 1'b0;
      plen_q       <= '0;
      glen_q       <= '0;
      pnum_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      dcnt_q       <= dcnt_d;
      lead_right_q <= lead_right_d;
      plen_q       <= plen_d;
      glen_q       <= glen_d;
      pnum_q       <= pnum_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    dcnt_d       = dcnt_q;
    lead_right_d = lead_right_q;
    plen_d       = plen_q;
    glen_d       = glen_q;
    pnum_d       = pnum_q;
    lead_go      = 1'b0;
    lag_go       = 1'b0;
    case (state_q)
      T_IDLE: begin
        if (start) begin
          lead_right_d = lead_right;
          plen_d       = pulse_len;
          glen_d       = gap_len;
          pnum_d       = pulse_num;
          lead_go      = 1'b1;
          if (delay == '0) begin
            lag_go  = 1'b1;
            state_d = T_RUN;
          end else begin
            dcnt_d  = delay;
            state_d = T_WAIT;
          end
        end
      end
      T_WAIT: begin
        if (dcnt_q != '0) dcnt_d = dcnt_q - DLY_W'(1);
        if (dcnt_q == DLY_W'(1)) begin
          lag_go  = 1'b1;
          state_d = T_RUN;
        end
      end
      T_RUN: begin
        if (!left_active && !right_active) state_d = T_DONE;
      end
      default: state_d = T_IDLE;
    endcase
    busy_d = (state_d != T_IDLE);
    done_d = (state_d == T_DONE);
  end

  // In the launch cycle the latch is not yet loaded, so the generators see the live inputs.
  assign idle     = (state_q == T_IDLE);
  assign lr_sel   = idle ? lead_right : lead_right_q;
  assign plen_sel = idle ? pulse_len  : plen_q;
  assign glen_sel = idle ? gap_len    : glen_q;
  assign pnum_sel = idle ? pulse_num  : pnum_q;
  assign left_go  = lr_sel ? lag_go  : lead_go;
  assign right_go = lr_sel ? lead_go : lag_go;

  mic_burst_gen u_left (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .go        (left_go),
    .pulse_len (plen_sel),
    .gap_len   (glen_sel),
    .pulse_num (pnum_sel),
    .out       (microphone_left),
    .active    (left_active),
    .state_dbg (left_dbg)
  );

  mic_burst_gen u_right (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .go        (right_go),
    .pulse_len (plen_sel),
    .gap_len   (glen_sel),
    .pulse_num (pnum_sel),
    .out       (microphone_right),
    .active    (right_active),
    .state_dbg (right_dbg)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign state_dbg = {state_q, left_dbg, right_dbg};

endmodule

// File: tb/tb_mic_pair_emulator.sv
// Cycle-exact scoreboard bench: an arithmetic burst model fills the expected queue at launch.
module tb_mic_pair_emulator;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        start;
  logic        lead_right;
  logic [16:0] delay;
  logic [7:0]  pulse_len;
  logic [7:0]  gap_len;
  logic [2:0]  pulse_num;
  logic        microphone_left;
  logic        microphone_right;
  logic        busy;
  logic        done;
  logic [5:0]  state_dbg;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];

  mic_pair_emulator dut (
    .HCLK             (HCLK),
    .HRESET           (HRESET),
    .start            (start),
    .lead_right       (lead_right),
    .delay            (delay),
    .pulse_len        (pulse_len),
    .gap_len          (gap_len),
    .pulse_num        (pulse_num),
    .microphone_left  (microphone_left),
    .microphone_right (microphone_right),
    .busy             (busy),
    .done             (done),
    .state_dbg        (state_dbg)
  );

  // clock / reset
  always #10 HCLK = ~HCLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // 1 when a channel whose first fall is rel cycles ago is low
  function automatic bit model_low(input int rel, input int p, input int g, input int n);
    if (rel < 0) return 1'b0;
    return ((rel / (p + g)) < n) && ((rel % (p + g)) < p);
  endfunction

  // Launch one burst; cycle k is sampled at the negedge inside cycle k.
  task automatic run_burst(input bit lr, input int dly, input int pl, input int gl, input int pn,
                           input int restart_at, input int reset_at, input string tag);
    int p, g, n, d_cyc, last, done_seen, exp_done;
    bit lead_l, lag_l, bz, dn;
    logic [3:0] e;
    p = (pl == 0) ? 1 : pl;
    g = (gl == 0) ? 1 : gl;
    n = (pn == 0) ? 1 : pn;
    d_cyc = dly + n * p + (n - 1) * g + 2;
    last = (reset_at > 0) ? reset_at + 8 : d_cyc + 3;
    exp_done = (reset_at > 0) ? 0 : 1;
    done_seen = 0;
    @(negedge HCLK);
    start = 1'b1; lead_right = lr; delay = 17'(dly);
    pulse_len = 8'(pl); gap_len = 8'(gl); pulse_num = 3'(pn);
    for (int k = 1; k <= last; k++) begin
      lead_l = !model_low(k - 1, p, g, n);
      lag_l  = !model_low(k - 1 - dly, p, g, n);
      bz = (k <= d_cyc);
      dn = (k == d_cyc);
      e = lr ? {lag_l, lead_l, bz, dn} : {lead_l, lag_l, bz, dn};
      if (reset_at > 0 && k > reset_at) e = 4'b1100;
      exp_q.push_back(e);
    end
    for (int k = 1; k <= last; k++) begin
      @(negedge HCLK);
      e = exp_q.pop_front();
      check_eq(tag, {28'd0, microphone_left, microphone_right, busy, done}, {28'd0, e});
      if (done) done_seen++;
      start = 1'b0;
      HRESET = (k == reset_at);
      if (k == 1 || k == restart_at) begin
        // scramble config after launch: it must have been latched
        delay = 17'($urandom_range(0, 30));
        pulse_len = 8'($urandom_range(0, 9));
        gap_len = 8'($urandom_range(0, 9));
        pulse_num = 3'($urandom_range(0, 7));
        lead_right = 1'($urandom_range(0, 1));
      end
      if (k == restart_at) start = 1'b1;
    end
    HRESET = 1'b0;
    check_eq({tag, "_done_count"}, done_seen, exp_done);
  endtask

  initial begin
    HRESET = 1'b1; start = 1'b0; lead_right = 1'b0; delay = '0;
    pulse_len = '0; gap_len = '0; pulse_num = '0;
    repeat (3) @(negedge HCLK);
    check_eq("reset", {28'd0, microphone_left, microphone_right, busy, done}, 32'hC);
    HRESET = 1'b0;
    @(negedge HCLK);
    check_eq("idle", {28'd0, microphone_left, microphone_right, busy, done}, 32'hC);

    run_burst(1'b0, 7000, 10, 5, 3, 0, 0, "left_lead");
    run_burst(1'b1, 7000, 10, 5, 3, 0, 0, "right_lead");
    run_burst(1'b0, 0, 10, 0, 1, 0, 0, "simultaneous");
    run_burst(1'b0, 100, 10, 5, 3, 50, 0, "restart_ignored");
    run_burst(1'b0, 100, 10, 5, 3, 0, 5, "mid_reset");
    run_burst(1'b1, 1, 3, 2, 2, 0, 0, "delay_one");
    run_burst(1'b0, 7500, 0, 0, 0, 0, 0, "zero_cfg");
    for (int i = 0; i < 8; i++) begin
      run_burst(1'($urandom_range(0, 1)), $urandom_range(0, 20), $urandom_range(0, 6),
                $urandom_range(0, 6), $urandom_range(0, 7), 0, 0, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
